// File: rtl/a_if_lane_packer.sv
// a_if_lane_packer: collects a serial byte stream into 8-lane groups and
// presents each completed (or flushed) group on the a_if producer lanes.
// A collection bank fills while a separate output bank holds the last
// emitted group, so the output never stalls.
//
// Handshake: a_if has no ready signal. A byte is consumed on every rising
// edge where in_valid=1. out_valid is a one-cycle pulse, and the lanes
// that go with it stay stable until the next pulse.
module a_if_lane_packer #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] PAD    = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_a2,
    output logic [DATA_W-1:0] out_a3,
    output logic [DATA_W-1:0] out_a4,
    output logic [DATA_W-1:0] out_a5,
    output logic [DATA_W-1:0] out_a6,
    output logic [DATA_W-1:0] out_a7,
    output logic [DATA_W-1:0] out_a8,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic              dbg_state
);

    // IDLE means idx=0 (no pending partial group); FILL means idx is 1..7.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t            state_q, state_n;
    logic [2:0]        idx_q, idx_n;
    logic [2:0]        wr_idx;
    logic              emit;
    logic              out_valid_n;
    logic [7:0]        drop_n;
    logic [DATA_W-1:0] lane_q [8];
    logic [DATA_W-1:0] lane_n [8];
    logic [DATA_W-1:0] out_q  [8];
    logic [DATA_W-1:0] out_n  [8];

    // Register bank: fill index, FSM state, collection and output lanes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            out_valid <= 1'b0;
            drop_cnt  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            out_valid <= out_valid_n;
            drop_cnt  <= drop_n;
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= lane_n[i];
                out_q[i]  <= out_n[i];
            end
        end
    end

    // Next state: accept the byte (with any sop abort) first, then let flush
    // pad and emit whatever partial group remains after that byte.
    always_comb begin
        lane_n  = lane_q;
        out_n   = out_q;
        idx_n   = idx_q;
        drop_n  = drop_cnt;
        wr_idx  = idx_q;
        emit    = 1'b0;

        if (in_valid) begin
            // sop mid-group discards the partial group and restarts at lane 0.
            if (in_sop && (idx_q != 3'd0)) begin
                wr_idx = 3'd0;
                if (drop_cnt != 8'hFF) begin
                    drop_n = drop_cnt + 8'd1;
                end
            end
            lane_n[wr_idx] = in_data;
            if (wr_idx == 3'd7) begin
                emit  = 1'b1;
                idx_n = 3'd0;
            end else begin
                idx_n = wr_idx + 3'd1;
            end
        end

        // A group that just completed leaves idx_n=0, so flush is a no-op
        // there and never produces a padded second pulse.
        if (flush && (idx_n != 3'd0)) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= int'(idx_n)) begin
                    lane_n[i] = PAD;
                end
            end
            emit  = 1'b1;
            idx_n = 3'd0;
        end

        if (emit) begin
            out_n = lane_n;
        end

        out_valid_n = emit;
        state_n     = (idx_n != 3'd0) ? S_FILL : S_IDLE;
    end

    // Output lanes and status are straight from registers.
    assign out_a     = out_q[0];
    assign out_a2    = out_q[1];
    assign out_a3    = out_q[2];
    assign out_a4    = out_q[3];
    assign out_a5    = out_q[4];
    assign out_a6    = out_q[5];
    assign out_a7    = out_q[6];
    assign out_a8    = out_q[7];
    assign busy      = (state_q == S_FILL);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_a_if_lane_packer.sv
// Bench for a_if_lane_packer: table of per-cycle vectors with expected
// outputs, followed by hand-written gapped-fill, reset and abort sequences.
module tb_a_if_lane_packer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sop;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_a, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7, out_a8;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       dbg_state;

  int tests_run;
  int tests_failed;

  a_if_lane_packer #(
    .DATA_W (8),
    .PAD    (8'hFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .flush     (flush),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_a2    (out_a2),
    .out_a3    (out_a3),
    .out_a4    (out_a4),
    .out_a5    (out_a5),
    .out_a6    (out_a6),
    .out_a7    (out_a7),
    .out_a8    (out_a8),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        sop;
    logic        fl;
    logic [7:0]  d;
    logic        ev;
    logic        eb;
    logic [63:0] eo;
    logic [7:0]  ed;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] lanes();
    return {out_a, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7, out_a8};
  endfunction

  function automatic void add(input logic v, input logic sop, input logic fl,
                              input logic [7:0] d, input logic ev, input logic eb,
                              input logic [63:0] eo, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.sop = sop; r.fl = fl; r.d = d;
    r.ev = ev; r.eb = eb; r.eo = eo; r.ed = ed;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, sample 1ns after the rising edge
  task automatic step(input logic v, input logic sop, input logic fl, input logic [7:0] d);
    @(negedge clock);
    in_valid = v;
    in_sop   = sop;
    flush    = fl;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  logic [63:0] hold;
  logic [63:0] exp_grp;
  logic [7:0]  edrop;
  int          got_bytes;
  int          cycles;
  logic        v_r;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    flush    = 1'b0;
    in_data  = 8'h00;

    // ---------------- vector table ----------------
    hold = 64'h0;
    // full group 0x11..0x88
    for (int i = 0; i < 7; i++) add(1, 0, 0, 8'((i + 1) * 17), 0, 1, hold, 8'd0);
    add(1, 0, 0, 8'h88, 1, 0, 64'h1122334455667788, 8'd0);
    hold = 64'h1122334455667788;
    add(0, 0, 0, 8'h00, 0, 0, hold, 8'd0);
    // abort after 3 bytes, restart with sop
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'hB1 + 8'(i), 0, 1, hold, 8'd0);
    add(1, 1, 0, 8'hA0, 0, 1, hold, 8'd1);
    for (int i = 1; i < 7; i++) add(1, 0, 0, 8'hA0 + 8'(i), 0, 1, hold, 8'd1);
    add(1, 0, 0, 8'hA7, 1, 0, 64'hA0A1A2A3A4A5A6A7, 8'd1);
    hold = 64'hA0A1A2A3A4A5A6A7;
    // flush alone after 5 bytes, then a second flush does nothing
    for (int i = 0; i < 5; i++) add(1, 0, 0, 8'hC1 + 8'(i), 0, 1, hold, 8'd1);
    add(0, 0, 1, 8'h00, 1, 0, 64'hC1C2C3C4C5FFFFFF, 8'd1);
    hold = 64'hC1C2C3C4C5FFFFFF;
    add(0, 0, 1, 8'h00, 0, 0, hold, 8'd1);
    // flush alongside the 8th byte: single normal emit
    for (int i = 0; i < 7; i++) add(1, 0, 0, 8'hD1 + 8'(i), 0, 1, hold, 8'd1);
    add(1, 0, 1, 8'hD8, 1, 0, 64'hD1D2D3D4D5D6D7D8, 8'd1);
    hold = 64'hD1D2D3D4D5D6D7D8;
    add(0, 0, 1, 8'h00, 0, 0, hold, 8'd1);
    // flush alongside the 5th byte pads lanes 5..7
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'hE1 + 8'(i), 0, 1, hold, 8'd1);
    add(1, 0, 1, 8'hE5, 1, 0, 64'hE1E2E3E4E5FFFFFF, 8'd1);
    hold = 64'hE1E2E3E4E5FFFFFF;
    // sop without valid is ignored; sop at idx 0 is a normal first byte
    add(0, 1, 0, 8'h99, 0, 0, hold, 8'd1);
    add(1, 1, 0, 8'hF1, 0, 1, hold, 8'd1);
    add(0, 0, 1, 8'h00, 1, 0, 64'hF1FFFFFFFFFFFFFF, 8'd1);
    hold = 64'hF1FFFFFFFFFFFFFF;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_lanes", lanes(), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_drop", 64'(drop_cnt), 64'h0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].sop, vecs[k].fl, vecs[k].d);
      check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].ev));
      check($sformatf("vec%0d_busy", k), 64'(busy), 64'(vecs[k].eb));
      check($sformatf("vec%0d_lanes", k), lanes(), vecs[k].eo);
      check($sformatf("vec%0d_drop", k), 64'(drop_cnt), 64'(vecs[k].ed));
    end

    // ---------------- back-to-back then gapped ----------------
    exp_grp = 64'h0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'(i + 1));
      exp_grp = {exp_grp[55:0], 8'(i + 1)};
      if ((i % 8) == 7) begin
        check("b2b_pulse", 64'(out_valid), 64'h1);
        check("b2b_lanes", lanes(), exp_grp);
        hold = exp_grp;
      end else begin
        check("b2b_nopulse", 64'(out_valid), 64'h0);
        check("b2b_hold", lanes(), hold);
      end
    end
    got_bytes = 0;
    cycles    = 0;
    exp_grp   = 64'h0;
    while (got_bytes < 8 && cycles < 200) begin
      v_r = 1'($urandom_range(0, 1));
      step(v_r, 0, 0, 8'h21 + 8'(got_bytes));
      cycles++;
      if (v_r) begin
        exp_grp = {exp_grp[55:0], 8'h21 + 8'(got_bytes)};
        got_bytes++;
      end
      if (got_bytes == 8 && v_r) begin
        check("gap_pulse", 64'(out_valid), 64'h1);
        check("gap_lanes", lanes(), 64'h2122232425262728);
      end else begin
        check("gap_nopulse", 64'(out_valid), 64'h0);
        check("gap_hold", lanes(), 64'h090A0B0C0D0E0F10);
      end
    end
    check("gap_bytes_done", 64'(got_bytes), 64'd8);
    step(0, 0, 0, 8'h00);
    check("gap_busy_after", 64'(busy), 64'h0);

    // ---------------- asynchronous reset mid-group ----------------
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h41 + 8'(i));
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("areset_lanes", lanes(), 64'h0);
    check("areset_busy", 64'(busy), 64'h0);
    check("areset_drop", 64'(drop_cnt), 64'h0);
    check("areset_valid", 64'(out_valid), 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 8'h31 + 8'(i));
      if (i == 7) begin
        check("postrst_pulse", 64'(out_valid), 64'h1);
        check("postrst_lanes", lanes(), 64'h3132333435363738);
      end else begin
        check("postrst_nopulse", 64'(out_valid), 64'h0);
        check("postrst_zero", lanes(), 64'h0);
      end
    end
    check("postrst_drop", 64'(drop_cnt), 64'h0);

    // ---------------- drop counter saturation ----------------
    edrop = 8'd0;
    for (int n = 0; n < 300; n++) begin
      step(1, 1, 0, 8'hAA);
      if (n > 0 && edrop != 8'hFF) edrop = edrop + 8'd1;
      check("abort_nopulse_sop", 64'(out_valid), 64'h0);
      check("abort_drop", 64'(drop_cnt), 64'(edrop));
      step(1, 0, 0, 8'hBB);
      check("abort_nopulse", 64'(out_valid), 64'h0);
    end
    check("abort_sat", 64'(drop_cnt), 64'hFF);
    check("abort_lanes_hold", lanes(), 64'h3132333435363738);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
